// File: rtl/pokey_bus_master.sv
// pokey_bus_master
//   Bus initiator for the POKEY 6502-style register port. Generates a free-running
//   phi2 clock from clk and turns each accepted valid/ready request into exactly one
//   full phi2 bus period (phi2 low half followed by phi2 high half) with chip select
//   asserted. A one-cycle rsp_valid pulse follows every request; reads return data.
//
//   Ports:
//     clk, clr            system clock, synchronous active-high reset
//     req_valid/ready     request handshake; req_write/addr/wdata is the payload
//     rsp_valid, rsp_rdata  completion pulse and read data (held until next read)
//     phi2                bus clock, high while phase_cnt >= HALF
//     bus_a, bus_dout, bus_din, bus_rw, bus_cs0_n   peripheral register bus
//
//   Optional feature, macro POKEY_BUS_INIT_EN: after reset, one write of 0x03 to
//   address 0xF (SKCTL) is issued before the first request is accepted; it produces
//   no rsp_valid.
module pokey_bus_master #(
    parameter int unsigned CLK_DIV = 56
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       phi2,
    output logic [3:0] bus_a,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din,
    output logic       bus_rw,
    output logic       bus_cs0_n
);

    localparam int unsigned HALF = CLK_DIV / 2;
    localparam int unsigned PW   = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PHASE_HALF = PW'(HALF);

    typedef enum logic [1:0] {StIdle, StWait, StActive, StInit} state_e;

`ifdef POKEY_BUS_INIT_EN
    // Reset preloads the holding registers with the SKCTL write.
    localparam state_e     RST_STATE  = StInit;
    localparam logic       RST_WRITE  = 1'b1;
    localparam logic [3:0] RST_ADDR   = 4'hF;
    localparam logic [7:0] RST_WDATA  = 8'h03;
    localparam logic       RST_SILENT = 1'b1;
`else
    localparam state_e     RST_STATE  = StIdle;
    localparam logic       RST_WRITE  = 1'b0;
    localparam logic [3:0] RST_ADDR   = 4'h0;
    localparam logic [7:0] RST_WDATA  = 8'h00;
    localparam logic       RST_SILENT = 1'b0;
`endif

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          phi2_q;
    logic          boundary, accept, active_end;

    logic          hold_write_q;
    logic [3:0]    hold_addr_q;
    logic [7:0]    hold_wdata_q;
    logic          silent_q;     // current bus cycle is internal, suppress rsp_valid

    logic          cs_n_q, cs_n_d;
    logic          rw_q, rw_d;
    logic [3:0]    a_q, a_d;
    logic [7:0]    dout_q, dout_d;
    logic          rsp_valid_q;
    logic [7:0]    rsp_rdata_q;

    // Payload that will drive the bus; bypasses the holding registers when a
    // request is accepted right at the boundary and ACTIVE starts next cycle.
    logic          eff_write;
    logic [3:0]    eff_addr;
    logic [7:0]    eff_wdata;

    assign boundary   = (phase_q == PHASE_LAST);
    assign phase_d    = boundary ? '0 : phase_q + 1'b1;
    assign accept     = req_valid & req_ready;
    assign active_end = (state_q == StActive) && boundary;

    assign eff_write  = accept ? req_write : hold_write_q;
    assign eff_addr   = accept ? req_addr  : hold_addr_q;
    assign eff_wdata  = accept ? req_wdata : hold_wdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = boundary ? StActive : StWait;
                end
            end
            StWait, StInit: begin
                if (boundary) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (boundary) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: handshake and next values of the registered bus outputs
    always_comb begin
        req_ready = (state_q == StIdle);
        cs_n_d    = 1'b1;
        rw_d      = 1'b1;
        a_d       = 4'h0;
        dout_d    = 8'h00;
        if (state_d == StActive) begin
            cs_n_d = 1'b0;
            rw_d   = ~eff_write;
            a_d    = eff_addr;
            dout_d = eff_write ? eff_wdata : 8'h00;
        end
    end

    // Phase counter, phi2, holding registers, bus and response registers
    always_ff @(posedge clk) begin
        if (clr) begin
            phase_q      <= '0;
            phi2_q       <= 1'b0;
            hold_write_q <= RST_WRITE;
            hold_addr_q  <= RST_ADDR;
            hold_wdata_q <= RST_WDATA;
            silent_q     <= RST_SILENT;
            cs_n_q       <= 1'b1;
            rw_q         <= 1'b1;
            a_q          <= 4'h0;
            dout_q       <= 8'h00;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 8'h00;
        end else begin
            phase_q <= phase_d;
            phi2_q  <= (phase_d >= PHASE_HALF);
            if (accept) begin
                hold_write_q <= req_write;
                hold_addr_q  <= req_addr;
                hold_wdata_q <= req_wdata;
            end
            if (active_end) begin
                silent_q <= 1'b0;
            end
            cs_n_q      <= cs_n_d;
            rw_q        <= rw_d;
            a_q         <= a_d;
            dout_q      <= dout_d;
            rsp_valid_q <= active_end & ~silent_q;
            // Peripheral updated bus_din at the phi2 rise; sample at end of period.
            if (active_end && !hold_write_q) begin
                rsp_rdata_q <= bus_din;
            end
        end
    end

    assign phi2      = phi2_q;
    assign bus_cs0_n = cs_n_q;
    assign bus_rw    = rw_q;
    assign bus_a     = a_q;
    assign bus_dout  = dout_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_pokey_bus_master.sv
// Testbench for pokey_bus_master (CLK_DIV = 56). A scoreboard queue holds the
// expected read data and accept-to-response latency of each request; a monitor
// process pops it on every rsp_valid. Bus windows and phi2 are checked directly.
module tb_pokey_bus_master;

    logic       clk = 1'b0;
    logic       clr;
    logic       req_valid, req_ready, req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       phi2;
    logic [3:0] bus_a;
    logic [7:0] bus_dout;
    logic [7:0] bus_din = 8'h00;
    logic       bus_rw, bus_cs0_n;

    pokey_bus_master #(.CLK_DIV(56)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .phi2      (phi2),
        .bus_a     (bus_a),
        .bus_dout  (bus_dout),
        .bus_din   (bus_din),
        .bus_rw    (bus_rw),
        .bus_cs0_n (bus_cs0_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ph    = 0;

    typedef struct {
        logic [7:0] rdata;
        int         acc;
        int         lat;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference phase: 0..55, restarted by clr
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ph  <= clr ? 0 : ((ph == 55) ? 0 : ph + 1);
    end

    // Peripheral model: latches writes / updates read data at the phi2 rise
    logic [7:0] mem [16];
    logic       mem_init = 1'b0;
    logic       phi2_d   = 1'b0;
    always @(posedge clk) begin
        phi2_d <= phi2;
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            mem[10]  <= 8'h5A;
            mem_init <= 1'b1;
        end else if (phi2 && !phi2_d && !bus_cs0_n) begin
            if (!bus_rw) mem[bus_a] <= bus_dout;
            else         bus_din    <= mem[bus_a];
        end
    end

    // phi2 must follow the reference phase at all times
    initial forever begin
        @(negedge clk);
        if (cyc > 0) chk("phi2_phase", int'(phi2), int'(ph >= 28));
    end

    // Response monitor
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!clr && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rsp_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", int'(rsp_rdata), int'(e.rdata));
                chk("rsp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    function automatic int lat_of(input int p);
        return (p == 55) ? 57 : (55 - p) + 57;
    endfunction

    // Issue one request at reference phase `phase`; optionally keep req_valid high.
    task automatic do_txn(input logic w, input logic [3:0] a, input logic [7:0] d,
                          input int phase, input bit push, input logic [7:0] exp_rd,
                          input bit keep);
        int n = 0;
        while (!(ph == phase && req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("txn_start_timeout", 1, 0);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        if (push) exp_q.push_back('{exp_rd, cyc, lat_of(phase)});
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        chk("accepted", int'(req_ready), 0);
    endtask

    // Observe the next chip-select window and check every bus field in it.
    task automatic watch_bus(input logic w, input logic [3:0] a, input logic [7:0] d);
        int n = 0, len = 0, errs = 0;
        while (bus_cs0_n && n < 200) begin
            if (req_ready) errs++;
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("cs_low_timeout", 1, 0);
        while (!bus_cs0_n && len < 100) begin
            if (bus_rw !== ~w || bus_a !== a || bus_dout !== (w ? d : 8'h00) ||
                phi2 !== (len >= 28) || req_ready !== 1'b0) errs++;
            len++;
            @(negedge clk);
        end
        chk("cs_low_len", len, 56);
        chk("bus_window_errs", errs, 0);
        chk("bus_a_after", int'(bus_a), 0);
        chk("bus_rw_after", int'(bus_rw), 1);
        chk("bus_dout_after", int'(bus_dout), 0);
    endtask

    initial begin
        int n, low, idle_err;
        clr       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_phi2", int'(phi2), 0);
        chk("rst_cs", int'(bus_cs0_n), 1);
        chk("rst_rw", int'(bus_rw), 1);
        chk("rst_a", int'(bus_a), 0);
        chk("rst_dout", int'(bus_dout), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_rdata", int'(rsp_rdata), 0);
`ifdef POKEY_BUS_INIT_EN
        chk("rst_ready", int'(req_ready), 0);
        clr = 1'b0;
        watch_bus(1'b1, 4'hF, 8'h03);
        chk("ready_after_init", int'(req_ready), 1);
`else
        chk("rst_ready", int'(req_ready), 1);
        clr = 1'b0;
`endif

        // Idle: no bus activity, no responses, always ready
        idle_err = 0;
        repeat (200) begin
            @(negedge clk);
            if (!bus_cs0_n || rsp_valid || !req_ready) idle_err++;
        end
        chk("idle_quiet", idle_err, 0);

        // Write at the boundary, read back a preset register, then write again
        do_txn(1'b1, 4'h1, 8'hAF, 55, 1'b1, 8'h00, 1'b0);
        watch_bus(1'b1, 4'h1, 8'hAF);
        do_txn(1'b0, 4'hA, 8'h00, 55, 1'b1, 8'h5A, 1'b0);
        watch_bus(1'b0, 4'hA, 8'h00);
        do_txn(1'b1, 4'h2, 8'h33, 55, 1'b1, 8'h5A, 1'b0);
        watch_bus(1'b1, 4'h2, 8'h33);

        // Mid-period accept, second request held with junk payload until ready
        do_txn(1'b1, 4'h3, 8'h11, 10, 1'b1, 8'h5A, 1'b1);
        low = 0;
        while (!req_ready && low < 300) begin
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 4'($urandom_range(0, 15));
            req_wdata = 8'($urandom_range(0, 255));
            low++;
            @(negedge clk);
        end
        chk("ready_low_cycles", low, 101);
        chk("reaccept_phase", ph, 0);
        req_write = 1'b0;
        req_addr  = 4'h1;
        req_wdata = 8'hC3;
        exp_q.push_back('{8'hAF, cyc, 112});
        @(negedge clk);
        req_valid = 1'b0;
        chk("accepted_held", int'(req_ready), 0);
        watch_bus(1'b0, 4'h1, 8'h00);

        // Abort with clr at phase 40 of ACTIVE
        do_txn(1'b1, 4'h4, 8'h77, 55, 1'b0, 8'h00, 1'b0);
        n = 0;
        while (!(ph == 40 && !bus_cs0_n) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached", int'(n < 200), 1);
        clr = 1'b1;
        @(negedge clk);
        chk("abort_cs", int'(bus_cs0_n), 1);
        chk("abort_phi2", int'(phi2), 0);
        chk("abort_a", int'(bus_a), 0);
        chk("abort_rw", int'(bus_rw), 1);
        chk("abort_rsp_valid", int'(rsp_valid), 0);
`ifdef POKEY_BUS_INIT_EN
        chk("abort_ready", int'(req_ready), 0);
`else
        chk("abort_ready", int'(req_ready), 1);
`endif
        clr = 1'b0;
        repeat (150) @(negedge clk);

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("pending_rsp", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
